// File: rtl/jtframe_db15_tx.sv
// jtframe_db15_tx: device-side DB15 joystick responder.
// Behaves like two chained 74HC165 shifters. Both player words are latched
// while the load strobe is low and shifted out LSB first, one bit per rising
// edge of joy_clk. Everything runs in the host clk domain, so joy_clk and
// joy_load are treated as asynchronous and synchronized first.
module jtframe_db15_tx #(
    parameter int WORDW = 12,
    parameter int SYNC  = 2     // synchronizer depth, must be >= 2
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [WORDW-1:0]                joy1,
    input  logic [WORDW-1:0]                joy2,
    input  logic                            joy_clk,
    input  logic                            joy_load,
    output logic                            joy_data,
    output logic                            frame_done,
    output logic [$clog2(2*WORDW+1)-1:0]    bit_cnt
);

    localparam int FW = 2 * WORDW;
    localparam int CW = $clog2(FW + 1);
    localparam logic [CW-1:0] LAST = CW'(FW);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_SHIFT = 2'd2
    } state_t;

    logic [SYNC-1:0] r_clk_sync;
    logic [SYNC-1:0] r_ld_sync;
    logic            r_clk_hist;

    state_t          r_state;
    logic [FW-1:0]   r_shift;
    logic [CW-1:0]   r_cnt;
    logic            r_done;

    state_t          w_state_nxt;
    logic [FW-1:0]   w_shift_nxt;
    logic [CW-1:0]   w_cnt_nxt;
    logic            w_done_nxt;
    logic            w_clk_rise;
    logic            w_ld_act;
    logic [FW-1:0]   w_frame;

    // Synchronize joy_clk / joy_load and keep one history bit for edge detection.
    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // the pre-edge value of its neighbour; blocking here would collapse the chain.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_clk_sync <= '0;
            r_ld_sync  <= '1;   // load strobe is active-low, so idle high
            r_clk_hist <= 1'b0;
        end else begin
            r_clk_sync <= {r_clk_sync[SYNC-2:0], joy_clk};
            r_ld_sync  <= {r_ld_sync[SYNC-2:0], joy_load};
            r_clk_hist <= r_clk_sync[SYNC-1];
        end
    end

    assign w_clk_rise = r_clk_sync[SYNC-1] & ~r_clk_hist;
    assign w_ld_act   = ~r_ld_sync[SYNC-1];

    // Buttons are active-high at the ports but active-low on the wire.
    assign w_frame = ~{joy2, joy1};

    // Next-state and datapath update; an active load overrides everything,
    // including a coincident joy_clk rise.
    // NOTE: every output of this block gets a default first, so no path can
    // leave a value unassigned and infer a latch.
    always_comb begin
        w_state_nxt = r_state;
        w_shift_nxt = r_shift;
        w_cnt_nxt   = r_cnt;
        w_done_nxt  = 1'b0;
        if (w_ld_act) begin
            w_state_nxt = ST_LOAD;
            w_shift_nxt = w_frame;
            w_cnt_nxt   = '0;
        end else begin
            case (r_state)
                ST_LOAD: begin
                    // Strobe released: the last transparent load is the frame.
                    w_state_nxt = ST_SHIFT;
                end
                ST_SHIFT: begin
                    if (w_clk_rise) begin
                        w_shift_nxt = {1'b1, r_shift[FW-1:1]};
                        w_cnt_nxt   = r_cnt + 1'b1;
                        if (r_cnt == LAST - 1'b1) begin
                            w_done_nxt  = 1'b1;
                            w_state_nxt = ST_IDLE;
                        end
                    end
                end
                ST_IDLE: begin
                    // Serial-in is tied high; keep the register flushed.
                    w_shift_nxt = '1;
                end
                default: begin
                    // Unreachable encoding: fall back to a quiet line.
                    w_state_nxt = ST_IDLE;
                    w_shift_nxt = '1;
                    w_cnt_nxt   = '0;
                end
            endcase
        end
    end

    // State, shift register and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_shift <= '1;
            r_cnt   <= '0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_shift <= w_shift_nxt;
            r_cnt   <= w_cnt_nxt;
            r_done  <= w_done_nxt;
        end
    end

    assign joy_data   = r_shift[0];
    assign frame_done = r_done;
    assign bit_cnt    = r_cnt;

endmodule

// File: tb/tb_jtframe_db15_tx.sv
// Testbench for jtframe_db15_tx: drives the reader side of the DB15 protocol
// and compares the serial stream against a frame model built from the word
// values, for SYNC=2 (main instance) and SYNC=3 (latency instance).
module tb_jtframe_db15_tx;

    localparam int W  = 12;
    localparam int FW = 2 * W;
    localparam int PH = 6;      // joy_clk / joy_load phase length, >= SYNC+2 for both DUTs

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [W-1:0]  joy1 = '0;
    logic [W-1:0]  joy2 = '0;
    logic          joy_clk = 1'b0;
    logic          joy_load = 1'b1;
    logic          joy_data, joy_data3;
    logic          frame_done, frame_done3;
    logic [4:0]    bit_cnt, bit_cnt3;

    int checks = 0;
    int errors = 0;
    int done_cnt = 0;
    int done_bad = 0;

    jtframe_db15_tx #(.WORDW(W), .SYNC(2)) dut (
        .clk(clk), .rst(rst), .joy1(joy1), .joy2(joy2),
        .joy_clk(joy_clk), .joy_load(joy_load),
        .joy_data(joy_data), .frame_done(frame_done), .bit_cnt(bit_cnt)
    );

    jtframe_db15_tx #(.WORDW(W), .SYNC(3)) dut3 (
        .clk(clk), .rst(rst), .joy1(joy1), .joy2(joy2),
        .joy_clk(joy_clk), .joy_load(joy_load),
        .joy_data(joy_data3), .frame_done(frame_done3), .bit_cnt(bit_cnt3)
    );

    always #5 clk = ~clk;

    // Count cycles with frame_done high and note any pulse with the wrong count.
    always @(negedge clk) begin
        if (frame_done === 1'b1) begin
            done_cnt++;
            if (bit_cnt !== 5'(FW)) done_bad++;
        end
    end

    // Expected serial bit after 'idx' shifts of the frame latched from (j1, j2).
    function automatic logic model_bit(input logic [W-1:0] j1, input logic [W-1:0] j2,
                                       input int idx);
        logic [FW-1:0] word;
        word = {j2, j1};
        if (idx >= FW) return 1'b1;
        return ~word[idx];
    endfunction

    function automatic logic [4:0] model_cnt(input int shifts);
        return (shifts >= FW) ? 5'(FW) : 5'(shifts);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_load(input logic [W-1:0] j1, input logic [W-1:0] j2);
        joy1 = j1;
        joy2 = j2;
        joy_load = 1'b0;
        repeat (PH) tick();
        joy_load = 1'b1;
        repeat (PH) tick();
    endtask

    task automatic shift_edge();
        joy_clk = 1'b1;
        repeat (PH) tick();
        joy_clk = 1'b0;
        repeat (PH) tick();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        for (int i = 0; i < 4; i++) begin
            joy_clk = (i % 2 == 0);
            tick();
            checks++;
            if (joy_data !== 1'b1 || bit_cnt !== 5'd0 || frame_done !== 1'b0 ||
                joy_data3 !== 1'b1 || bit_cnt3 !== 5'd0 || frame_done3 !== 1'b0) begin
                $display("FAIL reset cyc%0d: data=%b cnt=%0d done=%b (sync3 %b/%0d/%b), want 1/0/0",
                         i, joy_data, bit_cnt, frame_done, joy_data3, bit_cnt3, frame_done3);
                errors++;
            end
        end
        rst = 1'b0;
        joy_clk = 1'b0;
        repeat (PH) tick();
    endtask

    task automatic test_basic();
        logic [W-1:0] j1, j2;
        int d0;
        j1 = 12'h001;
        j2 = 12'h800;
        do_load(j1, j2);
        d0 = done_cnt;
        checks++;
        if (joy_data !== model_bit(j1, j2, 0) || bit_cnt !== 5'd0) begin
            $display("FAIL basic_load: data=%b cnt=%0d, want %b/0", joy_data, bit_cnt,
                     model_bit(j1, j2, 0));
            errors++;
        end
        for (int k = 1; k <= FW; k++) begin
            shift_edge();
            checks++;
            if (joy_data !== model_bit(j1, j2, k) || bit_cnt !== model_cnt(k)) begin
                $display("FAIL basic_shift%0d: data=%b cnt=%0d, want %b/%0d", k, joy_data,
                         bit_cnt, model_bit(j1, j2, k), model_cnt(k));
                errors++;
            end
            if (k == FW - 1) begin
                checks++;
                if (done_cnt != d0) begin
                    $display("FAIL basic_early_done: pulses=%0d, want 0", done_cnt - d0);
                    errors++;
                end
            end
        end
        checks++;
        if (done_cnt - d0 != 1) begin
            $display("FAIL basic_done: pulse cycles=%0d, want 1", done_cnt - d0);
            errors++;
        end
    endtask

    task automatic test_overrun();
        int d0;
        d0 = done_cnt;
        for (int k = 0; k < 8; k++) begin
            shift_edge();
            checks++;
            if (joy_data !== 1'b1 || bit_cnt !== 5'(FW)) begin
                $display("FAIL overrun%0d: data=%b cnt=%0d, want 1/%0d", k, joy_data, bit_cnt, FW);
                errors++;
            end
        end
        checks++;
        if (done_cnt != d0) begin
            $display("FAIL overrun_done: extra pulses=%0d, want 0", done_cnt - d0);
            errors++;
        end
    endtask

    task automatic test_reload();
        logic [W-1:0] j2;
        int d0;
        j2 = W'($urandom);
        do_load(12'hFFF, j2);
        for (int k = 1; k <= 5; k++) begin
            shift_edge();
            checks++;
            if (joy_data !== model_bit(12'hFFF, j2, k) || bit_cnt !== model_cnt(k)) begin
                $display("FAIL reload_pre%0d: data=%b cnt=%0d, want %b/%0d", k, joy_data,
                         bit_cnt, model_bit(12'hFFF, j2, k), k);
                errors++;
            end
        end
        d0 = done_cnt;
        do_load(12'h000, j2);
        checks++;
        if (joy_data !== 1'b1 || bit_cnt !== 5'd0 || done_cnt != d0) begin
            $display("FAIL reload_load: data=%b cnt=%0d done=%0d, want 1/0/0", joy_data,
                     bit_cnt, done_cnt - d0);
            errors++;
        end
        for (int k = 1; k <= FW; k++) begin
            shift_edge();
            checks++;
            if (joy_data !== model_bit(12'h000, j2, k) || bit_cnt !== model_cnt(k)) begin
                $display("FAIL reload_shift%0d: data=%b cnt=%0d, want %b/%0d", k, joy_data,
                         bit_cnt, model_bit(12'h000, j2, k), k);
                errors++;
            end
        end
        checks++;
        if (done_cnt - d0 != 1) begin
            $display("FAIL reload_done: pulse cycles=%0d, want 1", done_cnt - d0);
            errors++;
        end
    endtask

    // Random words; inputs are scrambled during shifting and must not leak in.
    task automatic test_random();
        logic [W-1:0] j1, j2;
        int d0;
        for (int f = 0; f < 3; f++) begin
            j1 = W'($urandom);
            j2 = W'($urandom);
            do_load(j1, j2);
            d0 = done_cnt;
            for (int k = 1; k <= FW; k++) begin
                joy1 = W'($urandom);
                joy2 = W'($urandom);
                shift_edge();
                checks++;
                if (joy_data !== model_bit(j1, j2, k) || bit_cnt !== model_cnt(k) ||
                    joy_data3 !== model_bit(j1, j2, k) || bit_cnt3 !== model_cnt(k)) begin
                    $display("FAIL random_f%0d_b%0d: data=%b/%b cnt=%0d/%0d, want %b/%0d",
                             f, k, joy_data, joy_data3, bit_cnt, bit_cnt3,
                             model_bit(j1, j2, k), k);
                    errors++;
                end
            end
            checks++;
            if (done_cnt - d0 != 1) begin
                $display("FAIL random_done_f%0d: pulse cycles=%0d, want 1", f, done_cnt - d0);
                errors++;
            end
        end
    endtask

    task automatic test_simultaneous();
        logic [W-1:0] j1, j2;
        j1 = W'($urandom);
        j2 = W'($urandom);
        joy1 = j1;
        joy2 = j2;
        joy_clk  = 1'b1;
        joy_load = 1'b0;
        repeat (PH) tick();
        checks++;
        if (bit_cnt !== 5'd0 || joy_data !== ~j1[0]) begin
            $display("FAIL simul: data=%b cnt=%0d, want %b/0", joy_data, bit_cnt, ~j1[0]);
            errors++;
        end
        // Transparent load: bit 0 follows joy1[0] one cycle later.
        j1[0] = ~j1[0];
        joy1 = j1;
        tick();
        checks++;
        if (joy_data !== ~j1[0]) begin
            $display("FAIL load_track: data=%b, want %b", joy_data, ~j1[0]);
            errors++;
        end
        joy_load = 1'b1;
        repeat (PH) tick();
        joy_clk = 1'b0;
        repeat (PH) tick();
        checks++;
        if (bit_cnt !== 5'd0 || joy_data !== model_bit(j1, j2, 0)) begin
            $display("FAIL simul_release: data=%b cnt=%0d, want %b/0", joy_data, bit_cnt,
                     model_bit(j1, j2, 0));
            errors++;
        end
        shift_edge();
        checks++;
        if (bit_cnt !== 5'd1 || joy_data !== model_bit(j1, j2, 1)) begin
            $display("FAIL simul_first_shift: data=%b cnt=%0d, want %b/1", joy_data, bit_cnt,
                     model_bit(j1, j2, 1));
            errors++;
        end
    endtask

    // joy_clk rises just after edge T; SYNC=2 must update at T+3, SYNC=3 at T+4.
    task automatic test_latency();
        logic exp_old, exp_new;
        do_load(12'h002, 12'h000);
        exp_old = model_bit(12'h002, 12'h000, 0);
        exp_new = model_bit(12'h002, 12'h000, 1);
        joy_clk = 1'b1;                         // T is the edge just before this
        for (int c = 1; c <= 4; c++) begin
            tick();                             // now just after edge T+c
            checks++;
            if (joy_data !== ((c >= 3) ? exp_new : exp_old) ||
                joy_data3 !== ((c >= 4) ? exp_new : exp_old)) begin
                $display("FAIL latency_T+%0d: sync2=%b sync3=%b, want %b/%b", c, joy_data,
                         joy_data3, (c >= 3) ? exp_new : exp_old, (c >= 4) ? exp_new : exp_old);
                errors++;
            end
        end
        repeat (PH) tick();
        joy_clk = 1'b0;
        repeat (PH) tick();
    endtask

    task automatic test_reset_midframe();
        do_load(12'hFFF, 12'hFFF);
        shift_edge();
        shift_edge();
        rst = 1'b1;
        tick();
        checks++;
        if (joy_data !== 1'b1 || bit_cnt !== 5'd0 || frame_done !== 1'b0) begin
            $display("FAIL reset_mid: data=%b cnt=%0d done=%b, want 1/0/0", joy_data,
                     bit_cnt, frame_done);
            errors++;
        end
        rst = 1'b0;
        repeat (PH) tick();
        shift_edge();
        checks++;
        if (joy_data !== 1'b1 || bit_cnt !== 5'd0) begin
            $display("FAIL reset_idle_shift: data=%b cnt=%0d, want 1/0", joy_data, bit_cnt);
            errors++;
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_overrun();
        test_reload();
        test_random();
        test_simultaneous();
        test_latency();
        test_reset_midframe();
        checks++;
        if (done_bad != 0) begin
            $display("FAIL done_count_align: bad pulses=%0d, want 0", done_bad);
            errors++;
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
